hex_scan_scheduler: RTL
=======================

# hex_scan_scheduler

Time-multiplexed scan controller that shares one `hex_decoder` instance among `NUM_DIGITS` seven-segment digits. Each digit is shown in turn for a programmable dwell period, with a blanking gap between digits to suppress ghosting. New digit values arrive through a valid/ready load port and are committed atomically only at frame boundaries, so a frame never mixes old and new data. It sits between the lab's value-producing logic (counters, ALU results) and the board's multiplexed display pins.

## Interface
- `NUM_DIGITS`, 6: number of scanned digits; must be ≥ 2.
- `DWELL`, 50000: clock cycles each digit is lit; must be ≥ 1.
- `BLANK`, 2: clock cycles all digits are off before each digit; 0 means no gap.
- `clock  in  1`: single clock; all state changes on its rising edge.
- `reset  in  1`: asynchronous, active-high; clears all state immediately.
- `enable  in  1`: scan runs while high.
- `load_valid  in  1`: load request.
- `load_data  in  4*NUM_DIGITS`: nibble i (bits 4i+3:4i) is the value for digit i.
- `load_ready  out  1`: pending buffer empty; a load is accepted when `load_valid & load_ready`.
- `seg  out  7`: active-low segment pattern from the shared `hex_decoder` (bit 0 = segment a); 7'h7F means blank.
- `digit_en  out  NUM_DIGITS`: one-hot active-high digit enable; all zero when blank.
- `frame_done  out  1`: one-cycle pulse at each frame wrap.

## Operation
- Storage: `display` register (4*NUM_DIGITS bits), `pending` register with a `pend_full` flag, digit index `idx` (width $clog2(NUM_DIGITS)), dwell/blank counter (width $clog2(max(DWELL,BLANK)+1)).
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: outputs blank. If `pend_full`, commit `pending` to `display` and clear `pend_full` on the next edge. When `enable`=1, go to BLANK with `idx`=0 (or directly to SHOW if BLANK=0).
  - BLANK: `digit_en`=0 and `seg`=7'h7F for exactly BLANK cycles, then SHOW.
  - SHOW: `digit_en`=one-hot(`idx`), `seg`=decode(`display[idx]`) for exactly DWELL cycles. Then `idx` advances and the FSM returns to BLANK (or SHOW if BLANK=0).
- Wrap: when SHOW for `idx`=NUM_DIGITS-1 ends, `idx` wraps to 0 and `frame_done` pulses. If `pend_full` on that edge, `display` ← `pending` and `pend_full` clears.
- Load: accepted only when `pend_full`=0. Accept sets `pend_full` and captures `load_data`. `load_ready` = ~`pend_full`. A load while `load_ready`=0 is ignored and the data is not captured.
- Accept coinciding with a wrap edge (pending empty): data goes to `pending` and commits at the next wrap, not the current one.
- `enable` falling in any state: next edge goes to IDLE, `idx` and counters reset to 0, outputs blank, `pending` retained. Re-enable always restarts at digit 0.
- Reset mid-scan: all outputs go to their reset values immediately; any pending load is discarded.

## Timing
- Reset values: `seg`=7'h7F, `digit_en`=0, `frame_done`=0, `load_ready`=1. State IDLE, `idx`=0, `display`=0, `pend_full`=0.
- `seg`, `digit_en` and `frame_done` are registered and change on the edge entering the corresponding state. There is no combinational path from inputs to outputs except `load_ready` (from the flop).
- Enable-to-first-lit latency: 1 cycle to leave IDLE, plus BLANK cycles.
- Frame period: NUM_DIGITS × (BLANK + DWELL) cycles.
- `frame_done` is high for the first cycle of digit 0's BLANK (or SHOW if BLANK=0) after a wrap. It is not asserted on the initial start from IDLE.
- Commit-to-display latency: `load_ready` returns to 1 on the cycle after the wrap edge. New values appear on digit 0 at the start of the next frame.

## Test plan
All scenarios use NUM_DIGITS=4, DWELL=3, BLANK=1.
- Reset/idle: assert `reset` mid-SHOW → same cycle `seg`=7'h7F, `digit_en`=0, `load_ready`=1. After release with `enable`=0, outputs stay blank indefinitely.
- Basic scan: load 16'hA810 in IDLE, then raise `enable` → 1 cycle IDLE exit, then per digit: 1 blank cycle followed by 3 SHOW cycles.
  - Digit 0: `digit_en`=4'b0001, `seg`=7'h40.
  - Digit 1: `digit_en`=4'b0010, `seg`=7'h79.
  - Digit 2: `digit_en`=4'b0100, `seg`=7'h00.
  - Digit 3: `digit_en`=4'b1000, `seg`=7'h08.
  - `frame_done` pulses once every 16 cycles.
- Atomic commit: mid-frame, load 16'h1111 → `load_ready` drops the next cycle. Remaining digits of the current frame still show old values. After the wrap, all four digits show 7'h79 and `load_ready`=1.
- Back-pressure: with `pend_full`=1, assert `load_valid` with 16'hFFFF → data is not captured; the next frame shows the first pending value, not F.
- Wrap-edge accept: assert `load_valid` exactly on the wrap edge with pending empty → the value commits one full frame (16 cycles) later.
- Enable drop: deassert `enable` during digit 2's SHOW → next cycle outputs are blank and the FSM is in IDLE. Re-enable → scan restarts at digit 0 with no `frame_done` on the restart.

Source files
------------

// File: rtl/hex_scan_scheduler.sv
// hex_scan_scheduler: time-multiplexed seven-segment scan controller.
// One hex decoder is shared by all digits. Each digit gets a blanking gap
// followed by a dwell period. New digit values are staged in a pending buffer
// and committed only at frame boundaries, or while idle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | scan stopped, outputs blank, pending buffer may commit
//   S_BLANK | inter-digit gap, all digits off, lasts BLANK cycles
//   S_SHOW  | digit idx lit with decoded nibble, lasts DWELL cycles
module hex_scan_scheduler #(
  parameter int NUM_DIGITS = 6,
  parameter int DWELL      = 50000,
  parameter int BLANK      = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  // Down-counter reload values: the phase ends when the counter reads zero.
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pend_full_q, pend_full_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;

  logic                    wrap;
  logic                    commit;
  logic                    accept;
  logic [3:0]              dec_nib;

  // The single shared decoder: active-low segments, bit 0 = segment a.
  function automatic logic [6:0] hex_decoder(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state logic: scan sequencing, frame wrap, load accept and commit.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    display_d   = display_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    wrap        = 1'b0;
    commit      = 1'b0;
    accept      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          idx_d = '0;
          if (BLANK > 0) begin
            state_d = S_BLANK;
            cnt_d   = BLANK_LD;
          end else begin
            state_d = S_SHOW;
            cnt_d   = DWELL_LD;
          end
        end
      end
      S_BLANK: begin
        if (cnt_q == '0) begin
          state_d = S_SHOW;
          cnt_d   = DWELL_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SHOW: begin
        if (cnt_q == '0) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (BLANK > 0) begin
            state_d = S_BLANK;
            cnt_d   = BLANK_LD;
          end else begin
            state_d = S_SHOW;
            cnt_d   = DWELL_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Dropping enable overrides everything, including a wrap on this edge.
    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      wrap    = 1'b0;
    end

    // Commit and accept are exclusive: accept needs the buffer empty,
    // commit needs it full, so a load landing on a wrap waits a frame.
    commit = pend_full_q && ((state_q == S_IDLE) || wrap);
    accept = load_valid && !pend_full_q;

    if (commit) begin
      display_d   = pending_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pending_d   = load_data;
      pend_full_d = 1'b1;
    end
  end

  // Selects the nibble that will be shown after this edge for the decoder.
  always_comb begin
    dec_nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        dec_nib = display_d[4*i +: 4];
      end
    end
  end

  // Registered outputs are computed from the state being entered.
  always_comb begin
    seg_d        = SEG_OFF;
    digit_en_d   = '0;
    frame_done_d = wrap;
    if (state_d == S_SHOW) begin
      seg_d = hex_decoder(dec_nib);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_en_d[i] = (idx_d == IDX_W'(i));
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      display_q    <= '0;
      pending_q    <= '0;
      pend_full_q  <= 1'b0;
      seg_q        <= SEG_OFF;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      pend_full_q  <= pend_full_d;
      seg_q        <= seg_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = ~pend_full_q;
  assign seg        = seg_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule
